// File: rtl/wbs_uart_tx.sv
// Wishbone B4 pipelined slave feeding a byte FIFO drained by an 8N1 UART transmitter.
// Registers: word 0 = DATA (write pushes a byte), word 1 = STATUS (read clears overflow).
module wbs_uart_tx #(
    parameter int unsigned TICKS_PER_BAUD = 4,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_stall_o,
    output logic        wbs_ack_o,
    output logic        uart_tx_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (TICKS_PER_BAUD > 1) ? $clog2(TICKS_PER_BAUD) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic          req, push_req, rd_status, push, pop, ovf_set;
    logic          fifo_empty, fifo_full, busy, tick_last;
    logic [31:0]   status;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          ovf_q, ack_q;
    logic [31:0]   dat_q;
    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          unused_bits;

    assign unused_bits = ^{wbs_dat_i[31:8], wbs_sel_i[3:1]};

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign push_req   = req & wbs_we_i & (wbs_adr_i == 4'd0) & wbs_sel_i[0];
    assign rd_status  = req & ~wbs_we_i & (wbs_adr_i == 4'd1);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign push       = push_req & ~fifo_full;
    assign ovf_set    = push_req & fifo_full;
    assign busy       = (state_q != StIdle);
    assign status     = {16'd0, 8'(level_q), 4'd0, ovf_q, fifo_full, fifo_empty, busy};

    // FIFO storage needs no reset: pointers and level define validity.
    always_ff @(posedge wbs_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wbs_dat_i[7:0];
        end
    end

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LW'(push) - LW'(pop);
            // A new overflow on the clearing read edge wins.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (rd_status) begin
                ovf_q <= 1'b0;
            end
            ack_q <= req;
            dat_q <= rd_status ? status : '0;
        end
    end

    assign tick_last = (baud_q == CW'(TICKS_PER_BAUD - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = 3'd0;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick_last) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            StData: begin
                if (tick_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            StStop: begin
                if (tick_last) begin
                    baud_d = '0;
                    // Back-to-back frames: reload straight into START.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = 3'd0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // Line level is registered from the next state to keep the pin glitch-free.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign wbs_stall_o = 1'b0;
    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign uart_tx_o   = tx_q;

endmodule

// File: doc/wbs_uart_tx.md
# wbs_uart_tx

Wishbone B4 pipelined slave that queues bytes written by the bus master into a small FIFO and serializes them on a UART transmit pin (8N1, LSB first). It plugs into one slave slot of the one-master interconnect, next to the charlie7x5 display slave. The SPI-bridged master can use it for debug output. It exposes a data register and a status register.

## Interface
- TICKS_PER_BAUD, 4, clock cycles per UART bit; must be ≥ 2.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥ 2.

Ports:
- wbs_clk_i  in  1  sole clock; all logic on its rising edge.
- wbs_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle, already decoded for this slave.
- wbs_stb_i  in  1  request strobe.
- wbs_we_i  in  1  1 = write.
- wbs_adr_i  in  4  word address.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data, valid with ack.
- wbs_stall_o  out  1  tied 0; every request is accepted.
- wbs_ack_o  out  1  one-cycle acknowledge per request.
- uart_tx_o  out  1  serial output, idle high.

## Operation
- Request accepted on any rising edge with cyc & stb.
- Address 0 (DATA):
  - Write with sel[0]=1 pushes dat_i[7:0].
  - Write with sel[0]=0 is acked with no effect.
  - Read returns 0.
- Address 1 (STATUS), read only:
  - bit0 busy (transmitter not IDLE).
  - bit1 FIFO empty.
  - bit2 FIFO full.
  - bit3 overflow (sticky).
  - bits[15:8] FIFO level, zero-extended.
  - All other bits 0. Writes are acked and ignored.
- Address 2..15: reads return 0; writes are acked and ignored.
- Overflow: a push while the FIFO is full (level sampled before any same-cycle pop) drops the byte and sets overflow.
- Clearing overflow: an accepted STATUS read clears it on the same edge that latches dat_o. The returned value shows the pre-clear flag. If a new overflow occurs on that same edge, overflow stays set.
- Transmitter FSM: IDLE → START → DATA → STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, load bit counter 0, go to START.
  - START: tx=0 for TICKS_PER_BAUD cycles, then go to DATA.
  - DATA: tx=shift[0] for TICKS_PER_BAUD cycles per bit; shift right after each bit; after bit 7, go to STOP.
  - STOP: tx=1 for TICKS_PER_BAUD cycles. On its last tick, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Push and pop on the same edge: level unchanged, both take effect.
- Reset (asynchronous, any time, including mid-frame):
  - uart_tx_o=1, wbs_ack_o=0, wbs_dat_o=0.
  - FIFO emptied, overflow=0, FSM in IDLE, baud counter 0.
  - An in-flight frame is aborted and not resumed.

## Timing
- wbs_ack_o is registered: high exactly one cycle after each accepted request edge. Back-to-back requests give back-to-back acks.
- wbs_dat_o is registered with ack; it is 0 in every cycle without ack.
- Write-to-line latency into an idle transmitter:
  - Edge N: byte pushed.
  - Edge N+1: IDLE pops it; uart_tx_o goes low after edge N+1.
- Frame length: exactly 10×TICKS_PER_BAUD cycles. Consecutive queued bytes produce contiguous frames.
- busy is 1 from the pop edge until the FSM returns to IDLE.
- STATUS level reflects the FIFO state before the accepting edge's push or pop.

## Test plan
Bench parameters: TICKS_PER_BAUD=4, FIFO_DEPTH=4.
1. Release reset, read STATUS → tx=1 throughout; ack one cycle later; dat_o=0x00000002.
2. Write 0xA5 to DATA (sel=0xF) → ack next cycle; tx low 4 cycles starting after the following edge; then bits 1,0,1,0,0,1,0,1 (4 cycles each); stop high 4 cycles; 40 cycles total; then idle high, busy=0.
3. Write 0x55 then 0x0F on consecutive cycles → two contiguous 40-cycle frames, no idle cycle between the stop bit of 0x55 and the start bit of 0x0F.
4. Write bytes 0x10..0x15 on six consecutive cycles → 0x10 is popped immediately and 0x15 is dropped.
   - STATUS read = 0x0000040D (level 4, full, overflow, busy).
   - Second STATUS read shows overflow=0.
   - Exactly 0x10..0x14 appear on the line.
5. Write to DATA with sel=0xE, and write to address 7 → both acked; STATUS shows empty; tx stays high.
6. Assert reset during data bit 3 of a frame with 2 bytes queued → tx=1 immediately; after release STATUS=0x00000002 and no further frames are sent.
